// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter.
// Holds the arbiter state encoding and the block-alignment helper.
package mem_arb_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int BLK_WORDS   = 8;
    localparam int MEM_LAT     = 4;
    localparam int OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FILL_I = 2'd2,
        FILL_D = 2'd3
    } arbState_e;

    function automatic logic [ADDR_W-1:0] blockAlign(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/mem_arbiter_blk_fill_seq.sv
// Block-fill sequencer: issues the eight pipelined reads of a block and
// counts returned words, flagging the last one. Shared by both fill states.
module blk_fill_seq
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              active,
    input  logic              rvalid,
    input  logic [ADDR_W-1:0] base,
    output logic              issueEn,
    output logic [ADDR_W-1:0] issueAddr,
    output logic              wordValid,
    output logic [2:0]        wordIdx,
    output logic              lastWord
);

    localparam logic [2:0] LAST_IDX = 3'(BLK_WORDS - 1);

    logic [ADDR_W-1:0] baseR;
    logic [2:0]        issCnt;
    logic [2:0]        rcvCnt;
    logic              issDoneR;

    // Counter and base registers; start reloads everything for a new block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baseR    <= {ADDR_W{1'b0}};
            issCnt   <= 3'd0;
            rcvCnt   <= 3'd0;
            issDoneR <= 1'b0;
        end else if (start) begin
            baseR    <= blockAlign(base);
            issCnt   <= 3'd0;
            rcvCnt   <= 3'd0;
            issDoneR <= 1'b0;
        end else begin
            if (issueEn) begin
                // Saturate on the last word: no ninth read is ever issued.
                if (issCnt == LAST_IDX) begin
                    issDoneR <= 1'b1;
                end else begin
                    issCnt <= issCnt + 3'd1;
                end
            end
            if (wordValid) begin
                rcvCnt <= rcvCnt + 3'd1;
            end
        end
    end

    // Issue address generation and receive qualification.
    always_comb begin
        issueEn   = active & ~issDoneR;
        issueAddr = baseR + ADDR_W'({issCnt, 1'b0});
        wordValid = active & rvalid;
        wordIdx   = rcvCnt;
        lastWord  = wordValid & (rcvCnt == LAST_IDX);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory port between I-cache fills, D-cache
// fills and D-cache write-through stores (store > D-fill > I-fill).
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_miss_req,
    input  logic [ADDR_W-1:0] ic_miss_addr,
    output logic              ic_fill_valid,
    output logic [2:0]        ic_fill_idx,
    output logic              ic_fill_done,
    input  logic              dc_miss_req,
    input  logic [ADDR_W-1:0] dc_miss_addr,
    output logic              dc_fill_valid,
    output logic [2:0]        dc_fill_idx,
    output logic              dc_fill_done,
    input  logic              dc_wr_req,
    input  logic [ADDR_W-1:0] dc_wr_addr,
    input  logic [DATA_W-1:0] dc_wr_data,
    output logic              dc_wr_ack,
    output logic [DATA_W-1:0] fill_data,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              busy
);

    arbState_e         state;
    arbState_e         stateNxt;
    logic [ADDR_W-1:0] wrAddrR;
    logic [DATA_W-1:0] wrDataR;
    logic              fillStart;
    logic [ADDR_W-1:0] fillBase;
    logic              fillActive;
    logic              seqIssueEn;
    logic [ADDR_W-1:0] seqIssueAddr;
    logic              seqWordValid;
    logic [2:0]        seqWordIdx;
    logic              seqLastWord;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    // Store address/data captured when a store wins arbitration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrAddrR <= {ADDR_W{1'b0}};
            wrDataR <= {DATA_W{1'b0}};
        end else if ((state == IDLE) && dc_wr_req) begin
            wrAddrR <= dc_wr_addr;
            wrDataR <= dc_wr_data;
        end
    end

    // Fixed-priority arbitration in IDLE and transaction completion.
    always_comb begin
        stateNxt  = state;
        fillStart = 1'b0;
        fillBase  = ic_miss_addr;
        case (state)
            IDLE: begin
                if (dc_wr_req) begin
                    stateNxt = WRITE;
                end else if (dc_miss_req) begin
                    stateNxt  = FILL_D;
                    fillStart = 1'b1;
                    fillBase  = dc_miss_addr;
                end else if (ic_miss_req) begin
                    stateNxt  = FILL_I;
                    fillStart = 1'b1;
                end else begin
                    stateNxt = IDLE;
                end
            end
            WRITE: stateNxt = IDLE;
            FILL_I, FILL_D: begin
                if (seqLastWord) begin
                    stateNxt = IDLE;
                end else begin
                    stateNxt = state;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    assign fillActive = (state == FILL_I) || (state == FILL_D);

    blk_fill_seq u_fillSeq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (fillStart),
        .active    (fillActive),
        .rvalid    (mem_rvalid),
        .base      (fillBase),
        .issueEn   (seqIssueEn),
        .issueAddr (seqIssueAddr),
        .wordValid (seqWordValid),
        .wordIdx   (seqWordIdx),
        .lastWord  (seqLastWord)
    );

    // Output steering: everything stays zero outside the owning state.
    always_comb begin
        ic_fill_valid = 1'b0;
        ic_fill_idx   = 3'd0;
        ic_fill_done  = 1'b0;
        dc_fill_valid = 1'b0;
        dc_fill_idx   = 3'd0;
        dc_fill_done  = 1'b0;
        dc_wr_ack     = 1'b0;
        fill_data     = {DATA_W{1'b0}};
        mem_en        = 1'b0;
        mem_wr        = 1'b0;
        mem_addr      = {ADDR_W{1'b0}};
        mem_wdata     = {DATA_W{1'b0}};
        busy          = (state != IDLE);
        case (state)
            WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = wrAddrR;
                mem_wdata = wrDataR;
                dc_wr_ack = 1'b1;
            end
            FILL_I: begin
                mem_en        = seqIssueEn;
                mem_addr      = seqIssueEn ? seqIssueAddr : {ADDR_W{1'b0}};
                ic_fill_valid = seqWordValid;
                ic_fill_idx   = seqWordValid ? seqWordIdx : 3'd0;
                ic_fill_done  = seqLastWord;
                fill_data     = seqWordValid ? mem_rdata : {DATA_W{1'b0}};
            end
            FILL_D: begin
                mem_en        = seqIssueEn;
                mem_addr      = seqIssueEn ? seqIssueAddr : {ADDR_W{1'b0}};
                dc_fill_valid = seqWordValid;
                dc_fill_idx   = seqWordValid ? seqWordIdx : 3'd0;
                dc_fill_done  = seqLastWord;
                fill_data     = seqWordValid ? mem_rdata : {DATA_W{1'b0}};
            end
            default: begin
                busy = (state != IDLE);
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: an in-order pipelined memory model,
// a transaction-level reference (priority order + memory image) and a monitor.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic ic_miss_req, dc_miss_req, dc_wr_req;
    logic [15:0] ic_miss_addr, dc_miss_addr, dc_wr_addr, dc_wr_data;
    logic ic_fill_valid, ic_fill_done, dc_fill_valid, dc_fill_done, dc_wr_ack;
    logic [2:0] ic_fill_idx, dc_fill_idx;
    logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
    logic mem_en, mem_wr, mem_rvalid, busy;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ic_miss_req(ic_miss_req), .ic_miss_addr(ic_miss_addr),
        .ic_fill_valid(ic_fill_valid), .ic_fill_idx(ic_fill_idx), .ic_fill_done(ic_fill_done),
        .dc_miss_req(dc_miss_req), .dc_miss_addr(dc_miss_addr),
        .dc_fill_valid(dc_fill_valid), .dc_fill_idx(dc_fill_idx), .dc_fill_done(dc_fill_done),
        .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
        .dc_wr_ack(dc_wr_ack), .fill_data(fill_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nChecks = 0;
    int nFail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] initWord(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    // ---------------- memory device: in-order, pipelined ----------------
    typedef struct { int due; logic [15:0] data; } resp_t;
    resp_t respQ[$];
    logic [15:0] devMem [logic [15:0]];
    int lastDue = 0;
    bit varLat = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (mem_en === 1'b1) begin
                if (mem_wr) begin
                    devMem[mem_addr] = mem_wdata;
                end else begin
                    resp_t r;
                    r.due = cyc + MEM_LAT;
                    if (varLat) r.due += int'($urandom_range(0, 3));
                    if (r.due <= lastDue) r.due = lastDue + 1;
                    lastDue = r.due;
                    r.data = devMem.exists(mem_addr) ? devMem[mem_addr] : initWord(mem_addr);
                    respQ.push_back(r);
                end
            end
        end
    end

    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (respQ.size() > 0 && respQ[0].due == cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = respQ[0].data;
                void'(respQ.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = 16'($urandom);
            end
        end
    end

    // ---------------- reference model: expected transactions ----------------
    typedef struct { bit wr; logic [15:0] addr; logic [15:0] data; } memop_t;
    typedef struct { bit side; logic [2:0] idx; logic [15:0] data; bit done; } fill_t;
    memop_t memQ[$];
    fill_t  fillQ[$];
    logic [15:0] refMem [logic [15:0]];

    function automatic logic [15:0] refRead(input logic [15:0] a);
        return refMem.exists(a) ? refMem[a] : initWord(a);
    endfunction

    task automatic expectWrite(input logic [15:0] a, input logic [15:0] d);
        memQ.push_back('{1'b1, a, d});
        refMem[a] = d;
    endtask

    task automatic expectFill(input bit side, input logic [15:0] a);
        logic [15:0] base;
        base = a & 16'hFFF0;
        for (int i = 0; i < BLK_WORDS; i++) begin
            logic [15:0] wa;
            wa = base + 16'(2 * i);
            memQ.push_back('{1'b0, wa, 16'h0000});
            fillQ.push_back('{side, 3'(i), refRead(wa), (i == BLK_WORDS - 1)});
        end
    endtask

    // ---------------- monitor ----------------
    bit wrAckSeen, dcDoneSeen, icDoneSeen;
    int busyCnt = 0;
    int icFirstCyc = -1, icDoneCyc = -1, dcIdx2Cyc = -1;
    logic [15:0] dcIdx2Data = 16'h0000;

    initial begin
        forever begin
            @(negedge clk);
            if (busy === 1'b1) busyCnt++;
            if (ic_fill_valid && dc_fill_valid) check("cross_valid", 32'd1, 32'd0);
            if (mem_en === 1'b1) begin
                if (memQ.size() == 0) begin
                    check("mem_unexpected", 32'(mem_addr), 32'hFFFFFFFF);
                end else begin
                    memop_t e;
                    e = memQ.pop_front();
                    check("mem_wr", 32'(mem_wr), 32'(e.wr));
                    check("mem_addr", 32'(mem_addr), 32'(e.addr));
                    if (e.wr) check("mem_wdata", 32'(mem_wdata), 32'(e.data));
                    check("wr_ack", 32'(dc_wr_ack), 32'(e.wr));
                end
            end else begin
                check("idle_ack", 32'(dc_wr_ack), 32'd0);
            end
            if (ic_fill_valid === 1'b1 || dc_fill_valid === 1'b1) begin
                if (fillQ.size() == 0) begin
                    check("fill_unexpected", {16'h0, fill_data}, 32'hFFFFFFFF);
                end else begin
                    fill_t f;
                    f = fillQ.pop_front();
                    check("fill_side", 32'(dc_fill_valid), 32'(f.side));
                    check("fill_idx", 32'(dc_fill_valid ? dc_fill_idx : ic_fill_idx), 32'(f.idx));
                    check("fill_data", 32'(fill_data), 32'(f.data));
                    check("fill_done", 32'(dc_fill_valid ? dc_fill_done : ic_fill_done), 32'(f.done));
                end
                if (ic_fill_valid && ic_fill_idx == 3'd0) icFirstCyc = cyc;
                if (dc_fill_valid && dc_fill_idx == 3'd2) begin
                    dcIdx2Data = fill_data;
                    dcIdx2Cyc  = cyc;
                end
            end else begin
                check("stray_done", 32'({ic_fill_done, dc_fill_done}), 32'd0);
                check("fill_data_zero", 32'(fill_data), 32'd0);
            end
            if (dc_wr_ack)    wrAckSeen  = 1'b1;
            if (dc_fill_done) dcDoneSeen = 1'b1;
            if (ic_fill_done) begin
                icDoneSeen = 1'b1;
                icDoneCyc  = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic runBatch(input bit doWr, input logic [15:0] wa, input logic [15:0] wd,
                            input bit doD, input logic [15:0] da,
                            input bit doI, input logic [15:0] ia, output int c0);
        int budget;
        if (doWr) expectWrite(wa, wd);
        if (doD)  expectFill(1'b1, da);
        if (doI)  expectFill(1'b0, ia);
        @(posedge clk); #2;
        wrAckSeen = 1'b0; dcDoneSeen = 1'b0; icDoneSeen = 1'b0;
        busyCnt = 0;
        c0 = cyc;
        dc_wr_req = doWr; dc_wr_addr = wa; dc_wr_data = wd;
        dc_miss_req = doD; dc_miss_addr = da;
        ic_miss_req = doI; ic_miss_addr = ia;
        budget = 300;
        while ((dc_wr_req || dc_miss_req || ic_miss_req) && budget > 0) begin
            @(posedge clk); #2;
            budget--;
            if (wrAckSeen)  dc_wr_req = 1'b0;
            if (dcDoneSeen) dc_miss_req = 1'b0;
            if (icDoneSeen) ic_miss_req = 1'b0;
        end
        check("batch_timeout", 32'(budget > 0), 32'd1);
        dc_wr_req = 1'b0; dc_miss_req = 1'b0; ic_miss_req = 1'b0;
        check("memq_drained", 32'(memQ.size()), 32'd0);
        check("fillq_drained", 32'(fillQ.size()), 32'd0);
        memQ.delete();
        fillQ.delete();
    endtask

    initial begin
        int c0;
        int budget;
        rst_n = 1'b0;
        ic_miss_req = 1'b0; dc_miss_req = 1'b0; dc_wr_req = 1'b0;
        ic_miss_addr = 16'h0000; dc_miss_addr = 16'h0000;
        dc_wr_addr = 16'h0000; dc_wr_data = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_outputs", 32'({ic_fill_valid, dc_fill_valid, dc_wr_ack, mem_wr}), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Nominal I-miss: timing of first word, done and busy length.
        runBatch(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h1236, c0);
        check("i_first_word_lat", 32'(icFirstCyc - c0), 32'd5);
        check("i_done_lat", 32'(icDoneCyc - c0), 32'd12);
        check("i_busy_cycles", 32'(busyCnt), 32'd12);

        // Single store.
        runBatch(1'b1, 16'h0040, 16'hBEEF, 1'b0, 16'h0, 1'b0, 16'h0, c0);
        check("wr_busy_cycles", 32'(busyCnt), 32'd1);

        // All three at once: store, then D fill, then I fill.
        runBatch(1'b1, 16'h0500, 16'h1234, 1'b1, 16'h2000, 1'b1, 16'h0100, c0);

        // Store visible to the following fill of the same block.
        runBatch(1'b1, 16'h3004, 16'h00AA, 1'b1, 16'h3000, 1'b0, 16'h0, c0);
        check("store_to_fill", 32'(dcIdx2Data), 32'h00AA);

        // Reset in the middle of an I fill.
        expectFill(1'b0, 16'h4A56);
        @(posedge clk); #2;
        c0 = cyc;
        ic_miss_addr = 16'h4A56;
        ic_miss_req = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        ic_miss_req = 1'b0;
        memQ.delete();
        fillQ.delete();
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_mem_en", 32'(mem_en), 32'd0);
        check("midrst_fill", 32'({ic_fill_valid, ic_fill_done}), 32'd0);
        budget = 50;
        while (respQ.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check("stale_drain_timeout", 32'(budget > 0), 32'd1);
        repeat (2) @(posedge clk);
        runBatch(1'b0, 16'h0, 16'h0, 1'b1, 16'h6ACE, 1'b0, 16'h0, c0);

        // Variable latency memory with randomized request mixes.
        varLat = 1'b1;
        runBatch(1'b0, 16'h0, 16'h0, 1'b1, 16'h7770, 1'b0, 16'h0, c0);
        for (int n = 0; n < 24; n++) begin
            bit w, d, i;
            logic [15:0] wa, da, ia;
            varLat = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            i = 1'($urandom_range(0, 1));
            if (!w && !d && !i) i = 1'b1;
            wa = 16'($urandom) & 16'hFFFE;
            da = 16'($urandom);
            ia = 16'($urandom);
            if ($urandom_range(0, 1) == 0) da = {wa[15:4], 4'($urandom)};
            runBatch(w, wa, 16'($urandom), d, da, i, ia, c0);
        end

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
